// File: rtl/axis_pred_demux_pkg.sv
// Shared types for the packet-level AXI4-Stream demultiplexer.
//   state_e   : frame state machine (idle decision / pass-through / discard)
//   frame_end : true when an accepted beat closes its frame
package axis_pred_demux_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPass = 2'd1,
    StDrop = 2'd2
  } state_e;

  // With tlast ignored, every beat is a complete frame.
  function automatic logic frame_end(input logic last, input bit last_enable);
    return last | ~last_enable;
  endfunction

endpackage

// File: rtl/axis_pred_demux.sv
// Packet-level AXI4-Stream demultiplexer. Steers each frame to the output picked by the tdest of
// its first beat; frames with an out-of-range tdest are discarded whole and reported on
// drop_pulse. Every frame spends one idle cycle on the routing decision.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   s_axis_*            single input stream (tdest sampled on the first beat only)
//   m_axis_*            M_COUNT output streams; data fields are shared, tvalid is one-hot
//   drop_pulse          one-cycle pulse after a dropped frame's last beat is accepted
module axis_pred_demux
  import axis_pred_demux_pkg::*;
#(
  parameter int M_COUNT     = 4,
  parameter int DATA_WIDTH  = 64,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
  parameter bit ID_ENABLE   = 1'b0,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_WIDTH  = 8,
  parameter bit USER_ENABLE = 1'b1,
  parameter int USER_WIDTH  = 1,
  parameter bit LAST_ENABLE = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]           s_axis_tkeep,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  input  logic [ID_WIDTH-1:0]             s_axis_tid,
  input  logic [DEST_WIDTH-1:0]           s_axis_tdest,
  input  logic [USER_WIDTH-1:0]           s_axis_tuser,
  output logic [M_COUNT*DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [M_COUNT*KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic [M_COUNT-1:0]              m_axis_tvalid,
  input  logic [M_COUNT-1:0]              m_axis_tready,
  output logic [M_COUNT-1:0]              m_axis_tlast,
  output logic [M_COUNT*ID_WIDTH-1:0]     m_axis_tid,
  output logic [M_COUNT*USER_WIDTH-1:0]   m_axis_tuser,
  output logic                            drop_pulse
);

  localparam int SelWidth = $clog2(M_COUNT);
  // When tdest cannot encode M_COUNT, every value is a legal output.
  localparam bit AllInRange = (DEST_WIDTH < 31) && (M_COUNT >= (1 << DEST_WIDTH));
  localparam logic [DEST_WIDTH-1:0] MCountDest = DEST_WIDTH'(M_COUNT);

  // Beat packing for the shared skid registers: {data, keep, last, id, user}.
  localparam int UserLsb   = 0;
  localparam int IdLsb     = USER_WIDTH;
  localparam int LastBit   = USER_WIDTH + ID_WIDTH;
  localparam int KeepLsb   = LastBit + 1;
  localparam int DataLsb   = KeepLsb + KEEP_WIDTH;
  localparam int BeatWidth = DataLsb + DATA_WIDTH;

  state_e                state_q, state_d;
  logic [SelWidth-1:0]   sel_q, sel_d;
  logic                  drop_q, drop_d;
  logic                  ready_int_q, ready_int_early;
  logic [M_COUNT-1:0]    m_valid_q, m_valid_d;
  logic [M_COUNT-1:0]    temp_valid_q, temp_valid_d;
  logic [BeatWidth-1:0]  main_beat_q, temp_beat_q, beat_in;
  logic                  in_accept, pass_beat, last_beat, dest_in_range, main_accept;
  logic [M_COUNT-1:0]    in_valid_oh;
  logic                  load_main_in, load_temp_in, load_main_temp;

  assign last_beat     = frame_end(s_axis_tlast, LAST_ENABLE);
  assign dest_in_range = AllInRange || (s_axis_tdest < MCountDest);
  assign in_accept     = s_axis_tvalid & s_axis_tready;
  assign pass_beat     = in_accept & (state_q == StPass);
  assign in_valid_oh   = pass_beat ? (M_COUNT'(1) << sel_q) : '0;
  assign beat_in       = {s_axis_tdata, s_axis_tkeep, last_beat, s_axis_tid, s_axis_tuser};

  always_comb begin
    s_axis_tready = 1'b0;
    unique case (state_q)
      StIdle:  s_axis_tready = 1'b0;
      StPass:  s_axis_tready = ready_int_q;
      StDrop:  s_axis_tready = 1'b1;
      default: s_axis_tready = 1'b0;
    endcase
  end

  // Frame state machine: decide in IDLE without consuming the beat, then pass or discard.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    drop_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (s_axis_tvalid) begin
          sel_d   = s_axis_tdest[SelWidth-1:0];
          state_d = dest_in_range ? StPass : StDrop;
        end
      end
      StPass: begin
        if (in_accept && last_beat) state_d = StIdle;
      end
      StDrop: begin
        if (in_accept && last_beat) begin
          drop_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      drop_q  <= drop_d;
    end
  end

  // Skid output stage. Only the held output's tready can drain main; while ready_int_q is set
  // temp is guaranteed empty, so an incoming beat always has somewhere to go.
  assign main_accept     = |(m_valid_q & m_axis_tready);
  assign ready_int_early = main_accept | (~|m_valid_q & ~|temp_valid_q);

  always_comb begin
    m_valid_d      = m_valid_q;
    temp_valid_d   = temp_valid_q;
    load_main_in   = 1'b0;
    load_temp_in   = 1'b0;
    load_main_temp = 1'b0;
    if (ready_int_q) begin
      if (main_accept || !(|m_valid_q)) begin
        m_valid_d    = in_valid_oh;
        load_main_in = 1'b1;
      end else begin
        temp_valid_d = in_valid_oh;
        load_temp_in = 1'b1;
      end
    end else if (main_accept) begin
      m_valid_d      = temp_valid_q;
      temp_valid_d   = '0;
      load_main_temp = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q    <= '0;
      temp_valid_q <= '0;
      ready_int_q  <= 1'b0;
    end else begin
      m_valid_q    <= m_valid_d;
      temp_valid_q <= temp_valid_d;
      ready_int_q  <= ready_int_early;
    end
  end

  always_ff @(posedge clk) begin
    if (load_main_in) begin
      main_beat_q <= beat_in;
    end else if (load_main_temp) begin
      main_beat_q <= temp_beat_q;
    end
    if (load_temp_in) begin
      temp_beat_q <= beat_in;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = {M_COUNT{main_beat_q[DataLsb +: DATA_WIDTH]}};
  assign m_axis_tkeep  = KEEP_ENABLE ? {M_COUNT{main_beat_q[KeepLsb +: KEEP_WIDTH]}} : '1;
  assign m_axis_tlast  = {M_COUNT{main_beat_q[LastBit]}};
  assign m_axis_tid    = ID_ENABLE ? {M_COUNT{main_beat_q[IdLsb +: ID_WIDTH]}} : '0;
  assign m_axis_tuser  = USER_ENABLE ? {M_COUNT{main_beat_q[UserLsb +: USER_WIDTH]}} : '0;
  assign drop_pulse    = drop_q;

endmodule

// File: tb/tb_axis_pred_demux.sv
// Scoreboard bench for axis_pred_demux (M_COUNT=4, DATA_WIDTH=64). The driver pushes each beat a
// routed frame should deliver onto the queue of its destination output; a negedge monitor pops
// and compares every handshake on m_axis, and also checks one-hot valid, hold-while-stalled and
// drop_pulse width.
module tb_axis_pred_demux;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [0:0]  user;
  } beat_t;

  logic         clk;
  logic         rst_n;
  logic [63:0]  s_axis_tdata;
  logic [7:0]   s_axis_tkeep;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [7:0]   s_axis_tid;
  logic [7:0]   s_axis_tdest;
  logic [0:0]   s_axis_tuser;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tkeep;
  logic [3:0]   m_axis_tvalid;
  logic [3:0]   m_axis_tready;
  logic [3:0]   m_axis_tlast;
  logic [31:0]  m_axis_tid;
  logic [3:0]   m_axis_tuser;
  logic         drop_pulse;

  axis_pred_demux dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tid    (s_axis_tid),
    .s_axis_tdest  (s_axis_tdest),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tid    (m_axis_tid),
    .m_axis_tuser  (m_axis_tuser),
    .drop_pulse    (drop_pulse)
  );

  int    n_vec = 0;
  int    n_err = 0;
  int    n_drop = 0;
  int    exp_drops = 0;
  int    rdy_mode = 1;  // 0: random m_axis_tready, 1: all ready
  beat_t exp_q[4][$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input bit ok, input string name, input logic [127:0] act,
                     input logic [127:0] req);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Output ready generator.
  initial begin
    m_axis_tready = '1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) m_axis_tready = 4'($urandom);
      else m_axis_tready = '1;
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic [3:0]  prev_stall;
    logic [63:0] prev_data;
    bit          prev_pulse;
    beat_t       got, want;
    prev_stall = '0;
    prev_data  = '0;
    prev_pulse = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = '0;
        prev_pulse = 1'b0;
      end else begin
        if (|m_axis_tvalid)
          chk($countones(m_axis_tvalid) == 1, "valid_onehot", 128'(m_axis_tvalid), 128'h1);
        if (|prev_stall) begin
          chk((m_axis_tvalid & prev_stall) == prev_stall, "hold_valid", 128'(m_axis_tvalid),
              128'(prev_stall));
          chk(m_axis_tdata[63:0] == prev_data, "hold_data", 128'(m_axis_tdata[63:0]),
              128'(prev_data));
        end
        for (int i = 0; i < 4; i++) begin
          if (m_axis_tvalid[i] && m_axis_tready[i]) begin
            got = {m_axis_tdata[i*64 +: 64], m_axis_tkeep[i*8 +: 8], m_axis_tlast[i],
                   m_axis_tuser[i]};
            if (exp_q[i].size() == 0) begin
              chk(1'b0, $sformatf("unexpected_beat_out%0d", i), 128'(got), 128'h0);
            end else begin
              want = exp_q[i].pop_front();
              chk(got == want, $sformatf("beat_out%0d", i), 128'(got), 128'(want));
              chk(m_axis_tid[i*8 +: 8] == 8'h0, "tid_zero", 128'(m_axis_tid[i*8 +: 8]), 128'h0);
            end
          end
        end
        if (drop_pulse) begin
          n_drop++;
          chk(!prev_pulse, "drop_pulse_width", 128'(prev_pulse), 128'h0);
        end
        prev_pulse = drop_pulse;
        prev_stall = m_axis_tvalid & ~m_axis_tready;
        prev_data  = m_axis_tdata[63:0];
      end
    end
  end

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until the handshake completes; returns just after that edge.
  task automatic send_beat(input logic [7:0] dest, input beat_t b);
    bit ok;
    ok = 1'b0;
    s_axis_tdata  = b.data;
    s_axis_tkeep  = b.keep;
    s_axis_tlast  = b.last;
    s_axis_tuser  = b.user;
    s_axis_tid    = 8'($urandom);
    s_axis_tdest  = dest;
    s_axis_tvalid = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk(1'b0, "accept_timeout", 128'h0, 128'h1);
  endtask

  function automatic beat_t rand_beat(input bit last);
    beat_t b;
    b.data = {$urandom, $urandom};
    b.keep = 8'($urandom);
    b.last = last;
    b.user = 1'($urandom);
    return b;
  endfunction

  // Frames with dest >= 4 are expected to vanish and raise one drop pulse.
  task automatic send_frame(input logic [7:0] dest, input int n, input bit scramble_dest);
    beat_t b;
    logic [7:0] d;
    if (dest >= 8'd4) exp_drops++;
    for (int k = 0; k < n; k++) begin
      b = rand_beat(k == n - 1);
      d = (k == 0 || !scramble_dest) ? dest : 8'($urandom);
      if (dest < 8'd4) exp_q[dest].push_back(b);
      send_beat(d, b);
    end
  endtask

  task automatic drain(input string name);
    int left;
    left = 1;
    for (int c = 0; c < 2000 && left != 0; c++) begin
      @(posedge clk);
      left = exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size();
    end
    #1;
    chk(left == 0, name, 128'(left), 128'h0);
  endtask

  initial begin
    int d0;
    beat_t b;
    rst_n         = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tid    = '0;
    s_axis_tdest  = '0;
    s_axis_tuser  = '0;
    repeat (3) @(posedge clk);
    #2;
    chk(m_axis_tvalid == 4'h0, "reset_m_valid", 128'(m_axis_tvalid), 128'h0);
    chk(s_axis_tready == 1'b0, "reset_s_ready", 128'(s_axis_tready), 128'h0);
    chk(drop_pulse == 1'b0, "reset_drop", 128'(drop_pulse), 128'h0);
    rst_n = 1'b1;
    idle(3);
    chk(s_axis_tready == 1'b0, "idle_s_ready", 128'(s_axis_tready), 128'h0);

    // Route with first-beat latency of two cycles.
    fork
      send_frame(8'd2, 4, 1'b0);
      begin
        @(negedge clk);
        @(negedge clk);
        chk(m_axis_tvalid == 4'h0, "latency_cycle1", 128'(m_axis_tvalid), 128'h0);
        @(negedge clk);
        chk(m_axis_tvalid == 4'b0100, "latency_cycle2", 128'(m_axis_tvalid), 128'h4);
      end
    join
    idle(2);
    drain("drain_route");

    // Drop at tdest == M_COUNT, then a routed single beat; tdest == M_COUNT-1 routes.
    d0 = n_drop;
    send_frame(8'd4, 3, 1'b0);
    s_axis_tvalid = 1'b0;
    @(posedge clk);
    #1;
    chk(n_drop == d0 + 1, "drop_pulse_count", 128'(n_drop), 128'(d0 + 1));
    send_frame(8'd0, 1, 1'b0);
    send_frame(8'd3, 2, 1'b0);
    send_frame(8'd255, 2, 1'b0);
    idle(2);
    drain("drain_drop");

    // Sticky destination and backpressure.
    send_frame(8'd3, 4, 1'b1);
    rdy_mode = 0;
    send_frame(8'd1, 8, 1'b0);
    idle(1);
    rdy_mode = 1;
    drain("drain_backpressure");

    // Reset in the middle of a frame: undelivered beats are lost.
    send_frame(8'd2, 0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      b = rand_beat(1'b0);
      exp_q[2].push_back(b);
      send_beat(8'd2, b);
    end
    s_axis_tdata = {$urandom, $urandom};
    #1;
    rst_n = 1'b0;
    #1;
    chk(m_axis_tvalid == 4'h0, "async_reset_valid", 128'(m_axis_tvalid), 128'h0);
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    s_axis_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(1);
    send_frame(8'd1, 1, 1'b0);
    idle(2);
    drain("drain_after_reset");

    // Randomized frames with random gaps and backpressure.
    rdy_mode = 0;
    for (int f = 0; f < 80; f++) begin
      int r;
      r = $urandom_range(0, 11);
      send_frame((r < 8) ? 8'(r % 4) : ((r < 10) ? 8'd4 : 8'($urandom_range(5, 255))),
                 $urandom_range(1, 6), 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(2);
    rdy_mode = 1;
    drain("drain_random");
    idle(4);
    chk(n_drop == exp_drops, "total_drops", 128'(n_drop), 128'(exp_drops));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
